event_encoder_4to2: RTL and testbench

Sequential 4-to-2 encoder: the encoding end of the 2-bit one-hot select path. Event pulses on four one-hot request lines are captured into a pending register. They are then issued one at a time as 2-bit codes over a valid/ready handshake, in the same bit-to-code mapping the decoder uses (line i ↔ code i). Events that arrive while their line is already pending are counted as drops.

---
 rtl/event_encoder_4to2.sv | 134 +++++++++++++
 tb/tb_event_encoder_4to2.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/event_encoder_4to2.sv
// event_encoder_4to2
//   Sequential 4-to-2 encoder. Event pulses on four one-hot request lines are
//   captured into a pending register and issued one at a time as 2-bit codes
//   over a valid/ready handshake (line i <-> code i). An event arriving on a
//   line that is already pending, and not being cleared this edge, is a drop.
//
//   Build option: define EVENT_ENCODER_ROUND_ROBIN_EN for round-robin
//   selection; otherwise the lowest pending index wins.
//
// Ports
//   clk      in   1       clock, rising-edge
//   rst      in   1       asynchronous active-high reset
//   D        in   4       event lines
//   Y        out  2       code of the issued event (registered)
//   valid    out  1       Y holds a valid code (registered)
//   ready    in   1       consumer accepts Y when valid && ready at an edge
//   pending  out  4       pending register
//   drop_cnt out  DROP_W  saturating dropped-event counter
module event_encoder_4to2 #(
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        D,
  output logic [1:0]        Y,
  output logic              valid,
  input  logic              ready,
  output logic [3:0]        pending,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [3:0]        p_q, p_d;
  logic [1:0]        y_q, y_d;
  logic              valid_q, valid_d;
  logic [DROP_W-1:0] cnt_q, cnt_d;

  logic              free;
  logic              load;
  logic [1:0]        sel;
  logic [3:0]        clr;
  logic [3:0]        drop_bits;
  logic [2:0]        drop_num;
  logic [DROP_W:0]   cnt_sum;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic       found;

  // Search upward from the line after the last one issued, wrapping at 3.
  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int j = 0; j < 4; j++) begin
      idx = ptr_q + 2'(j + 1);
      if (!found && p_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd3;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan from the top so the lowest set index wins.
  always_comb begin
    sel = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (p_q[j]) sel = 2'(j);
    end
  end
`endif

  // Output register accepts a new code when empty or being handed off now.
  assign free = !valid_q || ready;
  assign load = free && (p_q != 4'b0000);

  always_comb begin
    clr = 4'b0000;
    if (load) clr[sel] = 1'b1;
  end

  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    if (free) begin
      valid_d = load;
      if (load) y_d = sel;
    end
  end

  // A re-arriving event on a line cleared this edge simply re-pends it.
  assign p_d       = (p_q & ~clr) | D;
  assign drop_bits = D & p_q & ~clr;
  assign drop_num  = {2'b00, drop_bits[0]} + {2'b00, drop_bits[1]}
                   + {2'b00, drop_bits[2]} + {2'b00, drop_bits[3]};

  // One spare bit catches overflow; at most 4 is added, so one bit suffices.
  assign cnt_sum = {1'b0, cnt_q} + (DROP_W + 1)'(drop_num);

  always_comb begin
    cnt_d = cnt_sum[DROP_W-1:0];
    if (cnt_sum[DROP_W]) cnt_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= 4'b0000;
      y_q     <= 2'b00;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      p_q     <= p_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Y        = y_q;
  assign valid    = valid_q;
  assign pending  = p_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_event_encoder_4to2.sv
// Directed testbench for event_encoder_4to2. A DROP_W=8 instance carries the
// main sequence; a DROP_W=3 instance exercises counter saturation.
module tb_event_encoder_4to2;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic       ready;
  logic [1:0] y;
  logic       valid;
  logic [3:0] pending;
  logic [7:0] drop_cnt;

  logic [3:0] d_s;
  logic       ready_s;
  logic [1:0] y_s;
  logic       valid_s;
  logic [3:0] pending_s;
  logic [2:0] drop_cnt_s;

  int vectors;
  int miscompares;

  event_encoder_4to2 #(.DROP_W(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .D        (d),
    .Y        (y),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  event_encoder_4to2 #(.DROP_W(3)) u_sat (
    .clk      (clk),
    .rst      (rst),
    .D        (d_s),
    .Y        (y_s),
    .valid    (valid_s),
    .ready    (ready_s),
    .pending  (pending_s),
    .drop_cnt (drop_cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    d           = 4'b0000;
    ready       = 1'b1;
    d_s         = 4'b0000;
    ready_s     = 1'b0;
    #12;
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_y", {30'd0, y}, 32'd0);
    check("reset_pending", {28'd0, pending}, 32'd0);
    check("reset_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    #1;

    // Single event on line 2.
    d = 4'b0100;
    tick();
    check("t1_pend", {28'd0, pending}, 32'h4);
    check("t1_valid0", {31'd0, valid}, 32'd0);
    d = 4'b0000;
    tick();
    check("t1_valid1", {31'd0, valid}, 32'd1);
    check("t1_y", {30'd0, y}, 32'd2);
    tick();
    check("t1_valid_fall", {31'd0, valid}, 32'd0);
    check("t1_pend_empty", {28'd0, pending}, 32'd0);
    check("t1_drop", {24'd0, drop_cnt}, 32'd0);

    // Burst on all lines drains in index order.
    d = 4'b1111;
    tick();
    d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_valid", {31'd0, valid}, 32'd1);
      check("t2_y", {30'd0, y}, i);
    end
    tick();
    check("t2_valid_fall", {31'd0, valid}, 32'd0);

    // Backpressure with line 0 held for 10 cycles.
    ready = 1'b0;
    d     = 4'b0001;
    tick();
    check("t3_valid0", {31'd0, valid}, 32'd0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      check("t3_valid_hold", {31'd0, valid}, 32'd1);
      check("t3_y_hold", {30'd0, y}, 32'd0);
    end
    d = 4'b0000;
    check("t3_drop", {24'd0, drop_cnt}, 32'd8);
    check("t3_pend", {28'd0, pending}, 32'h1);
    ready = 1'b1;
    tick();
    check("t3_reissue_valid", {31'd0, valid}, 32'd1);
    check("t3_reissue_y", {30'd0, y}, 32'd0);
    check("t3_reissue_pend", {28'd0, pending}, 32'd0);
    tick();
    check("t3_valid_fall", {31'd0, valid}, 32'd0);

    // Saturation on the DROP_W=3 instance: 0, 3, 7, then stuck at 7.
    d_s = 4'b1111;
    tick();
    check("t4_drop_e1", {29'd0, drop_cnt_s}, 32'd0);
    tick();
    check("t4_drop_e2", {29'd0, drop_cnt_s}, 32'd3);
    tick();
    check("t4_drop_e3", {29'd0, drop_cnt_s}, 32'd7);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_drop_sat", {29'd0, drop_cnt_s}, 32'd7);
    end
    d_s = 4'b0000;

    // Lines 0 and 1 held with ready=1; one of them is re-dropped every cycle.
    pulse_reset();
    ready = 1'b1;
    d     = 4'b0011;
    tick();
    check("t5_pend", {28'd0, pending}, 32'h3);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_valid", {31'd0, valid}, 32'd1);
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
      check("t5_y", {30'd0, y}, i % 2);
`else
      check("t5_y", {30'd0, y}, 32'd0);
`endif
      check("t5_drop", {24'd0, drop_cnt}, i + 1);
    end
    d = 4'b0000;

    // Asynchronous reset between edges while a code is in flight.
    pulse_reset();
    ready = 1'b0;
    d     = 4'b1010;
    tick();
    tick();
    d = 4'b0000;
    check("t6_pre_valid", {31'd0, valid}, 32'd1);
    check("t6_pre_y", {30'd0, y}, 32'd1);
    check("t6_pre_pend", {28'd0, pending}, 32'ha);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid", {31'd0, valid}, 32'd0);
    check("t6_y", {30'd0, y}, 32'd0);
    check("t6_pend", {28'd0, pending}, 32'd0);
    check("t6_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    check("t6_post_valid", {31'd0, valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
